// File: rtl/rx_fifo_pkg.sv
// rx_fifo_pkg
// Shared types and defaults for the UART receive frame buffer.
// Contents:
//   DATA_WIDTH     default width of one received data word (matches the UART)
//   DEFAULT_DEPTH  default number of frame entries held by the buffer
//   rx_entry_t     one stored frame: error tags plus data word
package rx_fifo_pkg;

  localparam int DATA_WIDTH    = 8;
  localparam int DEFAULT_DEPTH = 4;

  // Tags sit above the data so the packed layout reads {par, stp, data}.
  typedef struct packed {
    logic                  par_err;
    logic                  stp_err;
    logic [DATA_WIDTH-1:0] data;
  } rx_entry_t;

endpackage

// File: rtl/rx_fifo_ctrl.sv
// rx_fifo_ctrl
// Pointer and status bookkeeping for the receive frame buffer.
// Ports:
//   CLK, RST   clock and synchronous active-high reset
//   push       a frame wants to enter the buffer this cycle
//   rd_ready   consumer accepts the head entry (ignored while empty)
//   ovf_clr    clears the sticky overflow flag
//   wr_en      storage write strobe for an accepted push
//   wr_addr    storage slot for the accepted push
//   rd_addr    storage slot of the head entry
//   full, empty, count  occupancy derived from the registered pointers
//   overflow   sticky: a push was rejected because the buffer was full
module rx_fifo_ctrl
  import rx_fifo_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             push,
  input  logic             rd_ready,
  input  logic             ovf_clr,
  output logic             wr_en,
  output logic [PTR_W-1:0] wr_addr,
  output logic [PTR_W-1:0] rd_addr,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count,
  output logic             overflow
);

  // One extra pointer bit distinguishes full from empty when the slot bits match.
  logic [PTR_W:0] wr_ptr;
  logic [PTR_W:0] rd_ptr;
  logic           pop;
  logic           ovf_set;

  // Status and handshake decode. A full buffer still takes a push when the
  // head leaves in the same cycle, because the freed slot is the one written.
  always_comb begin
    empty   = (wr_ptr == rd_ptr);
    full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
              (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    count   = wr_ptr - rd_ptr;
    pop     = rd_ready && !empty;
    wr_en   = push && (!full || pop);
    ovf_set = push && full && !pop;
    wr_addr = wr_ptr[PTR_W-1:0];
    rd_addr = rd_ptr[PTR_W-1:0];
  end

  // Pointer registers; both wrap naturally in binary.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Sticky overflow; a new loss outranks a clear arriving in the same cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      overflow <= 1'b0;
    end else if (ovf_set) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: rtl/rx_frame_fifo.sv
// rx_frame_fifo
// Receive-side frame buffer behind the UART RX deserializer. Captures each
// completed frame (data plus parity/stop error tags) on the one-cycle
// completion pulses and presents frames first-word-fall-through.
// Ports:
//   CLK, RST                 clock and synchronous active-high reset
//   P_DATA                   deserialized frame data
//   Data_Valid               pulse: clean frame complete
//   Parity_Error, Stop_Error pulses: frame complete with that error
//   DROP_ERR                 1 = discard frames carrying any error
//   ovf_clr                  clears the sticky overflow flag
//   rd_ready                 consumer accepts the head entry
//   rd_valid, rd_data, rd_par_err, rd_stp_err  head entry, zeros when empty
//   full, empty, count       occupancy
//   overflow                 sticky: a frame was lost to a full buffer
module rx_frame_fifo
  import rx_fifo_pkg::rx_entry_t;
  import rx_fifo_pkg::DEFAULT_DEPTH;
#(
  parameter int DATA_WIDTH = rx_fifo_pkg::DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int PTR_W      = $clog2(DEPTH)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  Parity_Error,
  input  logic                  Stop_Error,
  input  logic                  DROP_ERR,
  input  logic                  ovf_clr,
  input  logic                  rd_ready,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_par_err,
  output logic                  rd_stp_err,
  output logic                  full,
  output logic                  empty,
  output logic [PTR_W:0]        count,
  output logic                  overflow
);

  // Storage entries use the shared frame layout; DATA_WIDTH must stay at the
  // package width for the struct fields to line up with the ports.
  rx_entry_t        mem [DEPTH];
  rx_entry_t        head;
  logic             push;
  logic             wr_en;
  logic [PTR_W-1:0] wr_addr;
  logic [PTR_W-1:0] rd_addr;

  // Any completion pulse is a frame; errored frames vanish when DROP_ERR is
  // set, before they can reach the controller, so they never count as losses.
  always_comb begin
    push = (Data_Valid || Parity_Error || Stop_Error) &&
           !((Parity_Error || Stop_Error) && DROP_ERR);
  end

  rx_fifo_ctrl #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_ctrl (
    .CLK      (CLK),
    .RST      (RST),
    .push     (push),
    .rd_ready (rd_ready),
    .ovf_clr  (ovf_clr),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .rd_addr  (rd_addr),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow)
  );

  // Frame storage is deliberately not reset; the empty mask hides stale slots.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[wr_addr] <= '{par_err: Parity_Error, stp_err: Stop_Error, data: P_DATA};
    end
  end

  // Head presentation: combinational from the read slot, forced to zero when
  // nothing is held so the consumer never sees stale data.
  always_comb begin
    head       = mem[rd_addr];
    rd_valid   = !empty;
    rd_data    = empty ? '0 : head.data;
    rd_par_err = !empty && head.par_err;
    rd_stp_err = !empty && head.stp_err;
  end

endmodule

// File: tb/tb_rx_frame_fifo.sv
// tb_rx_frame_fifo
// Directed steps from the frame-buffer test plan followed by a randomized run,
// all compared against a queue-based model of the buffer after every edge.
module tb_rx_frame_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int PW    = $clog2(DEPTH);

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic [DW-1:0] P_DATA = '0;
  logic          Data_Valid = 1'b0;
  logic          Parity_Error = 1'b0;
  logic          Stop_Error = 1'b0;
  logic          DROP_ERR = 1'b0;
  logic          ovf_clr = 1'b0;
  logic          rd_ready = 1'b0;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          rd_par_err;
  logic          rd_stp_err;
  logic          full;
  logic          empty;
  logic [PW:0]   count;
  logic          overflow;

  int test_count = 0;
  int fail_count = 0;

  // Reference model: an ordered list of held frames {par, stp, data} and the
  // sticky loss flag.
  logic [DW+1:0] model_q[$];
  logic          model_ovf = 1'b0;

  rx_frame_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .P_DATA       (P_DATA),
    .Data_Valid   (Data_Valid),
    .Parity_Error (Parity_Error),
    .Stop_Error   (Stop_Error),
    .DROP_ERR     (DROP_ERR),
    .ovf_clr      (ovf_clr),
    .rd_ready     (rd_ready),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .rd_par_err   (rd_par_err),
    .rd_stp_err   (rd_stp_err),
    .full         (full),
    .empty        (empty),
    .count        (count),
    .overflow     (overflow)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    test_count++;
    assert (obs === exp) else begin
      fail_count++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // What one clock edge does to the held frames, in terms of whole frames.
  task automatic modelStep(input logic dv, input logic pe, input logic se,
                           input logic [DW-1:0] d, input logic drop,
                           input logic rdy, input logic clr, input logic rst);
    bit want_in;
    bit take_out;
    if (rst) begin
      model_q.delete();
      model_ovf = 1'b0;
      return;
    end
    want_in  = (dv || pe || se) && !((pe || se) && drop);
    take_out = (model_q.size() != 0) && rdy;
    if (want_in && model_q.size() == DEPTH && !take_out) begin
      model_ovf = 1'b1;
      want_in   = 1'b0;
    end else if (clr) begin
      model_ovf = 1'b0;
    end
    if (take_out) void'(model_q.pop_front());
    if (want_in) model_q.push_back({pe, se, d});
  endtask

  task automatic checkOutput(input string step);
    logic [DW+1:0] head;
    logic          have;
    have = (model_q.size() != 0);
    head = have ? model_q[0] : '0;
    check({step, ".rd_valid"},   32'(rd_valid),   32'(have));
    check({step, ".rd_data"},    32'(rd_data),    32'(head[DW-1:0]));
    check({step, ".rd_par_err"}, 32'(rd_par_err), 32'(head[DW+1]));
    check({step, ".rd_stp_err"}, 32'(rd_stp_err), 32'(head[DW]));
    check({step, ".full"},       32'(full),       32'(model_q.size() == DEPTH));
    check({step, ".empty"},      32'(empty),      32'(!have));
    check({step, ".count"},      32'(count),      32'(model_q.size()));
    check({step, ".overflow"},   32'(overflow),   32'(model_ovf));
  endtask

  // Drive one cycle of inputs, clock it, then check #1 after the edge with
  // the single-cycle pulses already withdrawn.
  task automatic applyStimulus(input string step, input logic dv, input logic pe,
                               input logic se, input logic [DW-1:0] d,
                               input logic drop, input logic rdy,
                               input logic clr, input logic rst);
    Data_Valid   = dv;
    Parity_Error = pe;
    Stop_Error   = se;
    P_DATA       = d;
    DROP_ERR     = drop;
    rd_ready     = rdy;
    ovf_clr      = clr;
    RST          = rst;
    @(posedge CLK);
    modelStep(dv, pe, se, d, drop, rdy, clr, rst);
    #1;
    Data_Valid   = 1'b0;
    Parity_Error = 1'b0;
    Stop_Error   = 1'b0;
    rd_ready     = 1'b0;
    ovf_clr      = 1'b0;
    RST          = 1'b0;
    checkOutput(step);
  endtask

  initial begin
    logic [DW-1:0] rd;
    logic          dv, pe, se;
    int            kind;

    // Reset state
    applyStimulus("reset", 0, 0, 0, 8'h00, 0, 0, 0, 1);
    check("reset.empty_const", 32'(empty), 32'd1);

    // Single frame in, then out
    applyStimulus("push_a5", 1, 0, 0, 8'hA5, 0, 0, 0, 0);
    check("push_a5.data_const", 32'(rd_data), 32'hA5);
    check("push_a5.count_const", 32'(count), 32'd1);
    applyStimulus("pop_a5", 0, 0, 0, 8'h00, 0, 1, 0, 0);
    check("pop_a5.data_zero", 32'(rd_data), 32'h0);

    // Fill, overflow, drain in order
    applyStimulus("fill_11", 1, 0, 0, 8'h11, 0, 0, 0, 0);
    applyStimulus("fill_22", 1, 0, 0, 8'h22, 0, 0, 0, 0);
    applyStimulus("fill_33", 1, 0, 0, 8'h33, 0, 0, 0, 0);
    applyStimulus("fill_44", 1, 0, 0, 8'h44, 0, 0, 0, 0);
    check("fill.full_const", 32'(full), 32'd1);
    applyStimulus("ovf_55", 1, 0, 0, 8'h55, 0, 0, 0, 0);
    check("ovf_55.overflow_const", 32'(overflow), 32'd1);
    applyStimulus("ovf_clr0", 0, 0, 0, 8'h00, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      rd = rd_data;
      check("drain.order", 32'(rd), 32'(8'h11 * (i + 1)));
      applyStimulus("drain", 0, 0, 0, 8'h00, 0, 1, 0, 0);
    end

    // Full buffer: push and pop in the same cycle
    for (int i = 0; i < 4; i++) applyStimulus("refill", 1, 0, 0, 8'(8'h11 * (i + 1)), 0, 0, 0, 0);
    applyStimulus("full_push_pop_66", 1, 0, 0, 8'h66, 0, 1, 0, 0);
    check("full_push_pop_66.count_const", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) applyStimulus("drain66", 0, 0, 0, 8'h00, 0, 1, 0, 0);

    // Error frames kept, then dropped
    applyStimulus("par_keep_3c", 0, 1, 0, 8'h3C, 0, 0, 0, 0);
    check("par_keep_3c.tag_const", 32'(rd_par_err), 32'd1);
    applyStimulus("stp_drop", 0, 0, 1, 8'h77, 1, 0, 0, 0);
    check("stp_drop.count_const", 32'(count), 32'd1);
    applyStimulus("pop_3c", 0, 0, 0, 8'h00, 0, 1, 0, 0);

    // Pointer wrap with single-entry occupancy
    applyStimulus("wrap_first", 1, 0, 0, 8'hC0, 0, 0, 0, 0);
    for (int i = 1; i <= 10; i++) applyStimulus("wrap", 1, 0, 0, 8'(8'hC0 + i), 0, 1, 0, 0);
    applyStimulus("wrap_last", 0, 0, 0, 8'h00, 0, 1, 0, 0);

    // Overflow set and clear collide, then clear alone, then reset mid-run
    for (int i = 0; i < 4; i++) applyStimulus("ovf_fill", 1, 0, 0, 8'(8'hE0 + i), 0, 0, 0, 0);
    applyStimulus("ovf_set_vs_clr", 1, 0, 0, 8'hEE, 0, 0, 1, 0);
    applyStimulus("ovf_clr_alone", 0, 0, 0, 8'h00, 0, 0, 1, 0);
    applyStimulus("keep_two", 0, 0, 0, 8'h00, 0, 1, 0, 0);
    applyStimulus("keep_two", 0, 0, 0, 8'h00, 0, 1, 0, 0);
    applyStimulus("mid_reset", 0, 0, 0, 8'h00, 0, 0, 0, 1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      kind = int'($urandom_range(0, 9));
      dv = (kind < 3);
      pe = (kind == 3) || (kind == 5);
      se = (kind == 4) || (kind == 5);
      applyStimulus("random", dv, pe, se, 8'($urandom()), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 7) == 0),
                    1'($urandom_range(0, 99) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
